// File: rtl/mole_sched.sv
// mole_sched -- game-tick scheduler for a whack-a-mole LED game.
// Timing: one game tick every TICK_CYC clk cycles. A game is 24 mole spawns over 48 ticks,
// grouped into three phases whose spawns come closer together. All outputs are registered.
// Latency: spawn #1 comes TICK_CYC cycles after start is sampled; game_over comes TICK_CYC*49 cycles after it.
// Backpressure: none; the display side must latch mole_idx on the spawn strobe.
//
// Optional feature: define MOLE_PAUSE_EN to add the pause input. While pause is high in ARM
// or RUN, game timing freezes and resumes where it stopped.
//
// Ports:
//   clk        system clock, rising-edge
//   rst_n      asynchronous active-low reset
//   start      level; starts or restarts a game from IDLE/DONE, ignored in ARM/RUN
//   pause      (MOLE_PAUSE_EN only) freezes tick counting, state and outputs
//   spawn      one-cycle strobe, new mole available on mole_idx
//   mole_idx   LED index of the current mole, stable between spawns
//   phase      0 = idle/lead-in, 1..3 = current point multiplier
//   spawn_cnt  spawns issued this game, saturates at 24
//   busy       high while a game is running (ARM, RUN)
//   game_over  high in DONE

module mole_sched #(
    parameter int          TICK_CYC  = 100000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef MOLE_PAUSE_EN
    input  logic       pause,
`endif
    output logic       spawn,
    output logic [2:0] mole_idx,
    output logic [1:0] phase,
    output logic [4:0] spawn_cnt,
    output logic       busy,
    output logic       game_over
);

    // Tick counter width. The guard keeps the width legal for tiny TICK_CYC values.
    localparam int CW = (TICK_CYC > 2) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYC - 1);

    localparam logic [5:0] LAST_TICK_IDX = 6'd48;
    localparam logic [4:0] MAX_SPAWNS    = 5'd24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] tick_cnt;
    logic [5:0]    tick_idx;
    logic [15:0]   lfsr;

    logic          tick;
    logic          hold;
    logic [5:0]    next_idx;
    logic [2:0]    mole_pick;
    logic [2:0]    lfsr_low;
    logic [15:0]   lfsr_next;

    // Spawn schedule in tick_idx terms. Phase 1 spawns every 3 ticks (0..21),
    // phase 2 every 2 ticks (24..38), and phase 3 every tick (40..47).
    function automatic logic sched_hit(input logic [5:0] ti);
        logic hit;
        hit = 1'b0;
        if (ti < 6'd24) begin
            hit = ((ti % 6'd3) == 6'd0);
        end else if (ti < 6'd40) begin
            hit = ~ti[0];
        end else if (ti < 6'd48) begin
            hit = 1'b1;
        end
        return hit;
    endfunction

    // A tick is the cycle in which the counter wraps.
    assign tick     = (tick_cnt == TICK_LAST);
    assign next_idx = tick_idx + 6'd1;

`ifdef MOLE_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // No immediate repeat. Bump the candidate by one, mod 8, if it matches the mole on display.
    assign lfsr_low  = lfsr[2:0];
    assign mole_pick = (lfsr_low == mole_idx) ? (lfsr_low + 3'd1) : lfsr_low;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1 (tap mask 0xB400).
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // The LFSR free-runs in every state and also during pause. A mole position then
    // depends on how long the player waited, not only on the position in the schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // Game FSM. All outputs are registered and change together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            tick_idx  <= '0;
            spawn     <= 1'b0;
            mole_idx  <= 3'd0;
            phase     <= 2'd0;
            spawn_cnt <= 5'd0;
            busy      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            spawn <= 1'b0;

            case (state)
                // Ticks are not counted here. A start that coincides with what would
                // be a tick therefore only arms the game.
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ARM;
                        tick_cnt  <= '0;
                        tick_idx  <= '0;
                        spawn_cnt <= 5'd0;
                        phase     <= 2'd0;
                        busy      <= 1'b1;
                        game_over <= 1'b0;
                    end
                end

                // Lead-in: wait one full tick period, then issue spawn #1.
                ARM: begin
                    if (!hold) begin
                        tick_cnt <= tick ? '0 : (tick_cnt + CW'(1));
                        if (tick) begin
                            state     <= RUN;
                            tick_idx  <= 6'd0;
                            spawn     <= 1'b1;
                            mole_idx  <= mole_pick;
                            spawn_cnt <= 5'd1;
                            phase     <= 2'd1;
                        end
                    end
                end

                RUN: begin
                    if (!hold) begin
                        tick_cnt <= tick ? '0 : (tick_cnt + CW'(1));
                        if (tick) begin
                            tick_idx <= next_idx;
                            if (next_idx == LAST_TICK_IDX) begin
                                state     <= DONE;
                                phase     <= 2'd0;
                                busy      <= 1'b0;
                                game_over <= 1'b1;
                            end else if (sched_hit(next_idx)) begin
                                spawn    <= 1'b1;
                                mole_idx <= mole_pick;
                                if (spawn_cnt != MAX_SPAWNS) begin
                                    spawn_cnt <= spawn_cnt + 5'd1;
                                end
                                // spawn_cnt still holds the old count. Spawns #9 and #17 open phases 2 and 3.
                                if (spawn_cnt == 5'd8) begin
                                    phase <= 2'd2;
                                end else if (spawn_cnt == 5'd16) begin
                                    phase <= 2'd3;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_sched.sv
// tb_mole_sched -- scoreboard bench for mole_sched with TICK_CYC=4.
// The stimulus side pushes the expected spawn events (edge number, phase, spawn_cnt) for each game.
// A negedge monitor pops one event for each spawn and checks it, along with mole_idx repeat and stability.

module tb_mole_sched;

    localparam int TC  = 4;
    localparam int BIG = 32'h3fffffff;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
`ifdef MOLE_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic       spawn;
    logic [2:0] mole_idx;
    logic [1:0] phase;
    logic [4:0] spawn_cnt;
    logic       busy;
    logic       game_over;

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;

    typedef struct {
        int edge_no;
        int ph;
        int cnt;
    } exp_t;

    exp_t sb[$];

    mole_sched #(
        .TICK_CYC (TC),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef MOLE_PAUSE_EN
        .pause    (pause),
`endif
        .spawn    (spawn),
        .mole_idx (mole_idx),
        .phase    (phase),
        .spawn_cnt(spawn_cnt),
        .busy     (busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Expected schedule for one game. Spawns fall at tick_idx 3k, 24+2k and 40+k, and each
    // tick_idx falls TC*(tick_idx+1) edges after the start edge. A pause after spawn #2
    // delays spawns from #3 on by shift. Only events before edge limit are pushed.
    task automatic push_game(input int t0, input int shift, input int limit);
        int n;
        int ti;
        int e;
        int ph;
        n = 0;
        for (int seg = 0; seg < 3; seg++) begin
            for (int k = 0; k < 8; k++) begin
                ti = (seg == 0) ? 3 * k : (seg == 1) ? 24 + 2 * k : 40 + k;
                n++;
                e  = t0 + TC + TC * ti + ((n >= 3) ? shift : 0);
                ph = (n <= 8) ? 1 : (n <= 16) ? 2 : 3;
                if (e < limit) sb.push_back('{e, ph, n});
            end
        end
    endtask

    // Drive start so that the next rising edge samples it. Returns that edge's number.
    task automatic start_game(output int t0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = edge_n;
    endtask

    task automatic wait_game_over(input int exp_edge, input string tag);
        int got;
        got = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (game_over) begin
                got = edge_n;
                break;
            end
        end
        chk({tag, "_game_over_edge"}, got, exp_edge);
        chk({tag, "_done_phase"}, int'(phase), 0);
        chk({tag, "_done_spawn_cnt"}, int'(spawn_cnt), 24);
        chk({tag, "_done_busy"}, int'(busy), 0);
        chk({tag, "_all_spawns_seen"}, sb.size(), 0);
    endtask

    task automatic chk_armed(input string tag);
        chk({tag, "_arm_busy"}, int'(busy), 1);
        chk({tag, "_arm_game_over"}, int'(game_over), 0);
        chk({tag, "_arm_spawn_cnt"}, int'(spawn_cnt), 0);
        chk({tag, "_arm_phase"}, int'(phase), 0);
    endtask

    // Monitor
    logic [2:0] prev_mole = 3'd0;
    exp_t       cur;

    always @(negedge clk) begin
        if (rst_n) begin
            if (spawn) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_spawn: spawn seen at edge %0d, expected none", edge_n);
                end else begin
                    cur = sb.pop_front();
                    chk("spawn_edge", edge_n, cur.edge_no);
                    chk("spawn_phase", int'(phase), cur.ph);
                    chk("spawn_cnt", int'(spawn_cnt), cur.cnt);
                end
                tests++;
                if (mole_idx == prev_mole) begin
                    fails++;
                    $display("FAIL mole_repeat: got %0d, required different from %0d", mole_idx, prev_mole);
                end
            end else begin
                tests++;
                if (mole_idx != prev_mole) begin
                    fails++;
                    $display("FAIL mole_stable: got %0d, required %0d without spawn", mole_idx, prev_mole);
                end
            end
        end
        prev_mole = mole_idx;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    int t0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spawn", int'(spawn), 0);
        chk("rst_mole_idx", int'(mole_idx), 0);
        chk("rst_phase", int'(phase), 0);
        chk("rst_spawn_cnt", int'(spawn_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_game_over", int'(game_over), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Game 1: single-cycle start pulse, full schedule
        start_game(t0);
        push_game(t0, 0, BIG);
        @(negedge clk);
        start = 1'b0;
        chk_armed("g1");
        wait_game_over(t0 + 196, "g1");
        repeat (5) @(negedge clk);
        chk("g1_game_over_holds", int'(game_over), 1);
        chk("g1_spawn_cnt_holds", int'(spawn_cnt), 24);

        // Game 2: restart from DONE, with start held high well into RUN
        start_game(t0);
        push_game(t0, 0, BIG);
        @(negedge clk);
        chk_armed("g2");
        while (edge_n < t0 + 150) @(negedge clk);
        start = 1'b0;
        wait_game_over(t0 + 196, "g2");

        // Game 3: reset mid-game at edge +50. No further spawns until a new start.
        start_game(t0);
        push_game(t0, 0, t0 + 50);
        @(negedge clk);
        start = 1'b0;
        while (edge_n < t0 + 50) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_spawn", int'(spawn), 0);
        chk("abort_mole_idx", int'(mole_idx), 0);
        chk("abort_phase", int'(phase), 0);
        chk("abort_spawn_cnt", int'(spawn_cnt), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_game_over", int'(game_over), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_spawns_before_reset", sb.size(), 0);
        chk("abort_idle_busy", int'(busy), 0);

        // Game 4: fresh start after the abort
        start_game(t0);
        push_game(t0, 0, BIG);
        @(negedge clk);
        start = 1'b0;
        chk_armed("g4");
        wait_game_over(t0 + 196, "g4");

`ifdef MOLE_PAUSE_EN
        // Game 5: pause for 10 cycles right after spawn #2
        start_game(t0);
        push_game(t0, 10, BIG);
        @(negedge clk);
        start = 1'b0;
        while (edge_n < t0 + 16) @(negedge clk);
        pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("pause_phase", int'(phase), 1);
            chk("pause_spawn_cnt", int'(spawn_cnt), 2);
            chk("pause_busy", int'(busy), 1);
        end
        pause = 1'b0;
        wait_game_over(t0 + 206, "g5");
`endif

        repeat (3) @(negedge clk);
        chk("final_scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mole_sched.md
MOLE_SCHED -- requirements
Module: mole_sched

Interface
REQ-001 Parameter TICK_CYC, default 100000000, clk cycles per game tick (minimum 2).
REQ-002 Parameter LFSR_SEED, default 16'hACE1, non-zero LFSR reset value.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level; sampled each clk edge; starts or restarts a game.
REQ-006 pause  input  1  freezes game timing (present only with MOLE_PAUSE_EN).
REQ-007 spawn  output  1  one-cycle strobe; display datapath latches mole_idx on it.
REQ-008 mole_idx  output  3  LED index of the current mole; valid and stable from spawn until the next spawn.
REQ-009 phase  output  2  0 idle/lead-in, 1/2/3 = current point multiplier.
REQ-010 spawn_cnt  output  5  spawns issued this game, 0..24.
REQ-011 busy  output  1  high in ARM and RUN.
REQ-012 game_over  output  1  level, high in DONE.

Function
REQ-013 The FSM SHALL have states IDLE, ARM, RUN, DONE; the state after reset is IDLE.
REQ-014 IDLE or DONE with start=1: go to ARM, clear the tick counter, tick_idx, spawn_cnt and phase; start SHALL be ignored in ARM and RUN.
REQ-015 The tick counter SHALL count 0..TICK_CYC-1 and wrap; the wrap cycle is one tick; ticks are counted only in ARM and RUN.
REQ-016 The first tick in ARM SHALL move to RUN and issue spawn #1 in that cycle, exactly TICK_CYC cycles after start is sampled.
REQ-017 RUN SHALL keep tick_idx (0..48), counted from spawn #1; spawns SHALL occur at tick_idx 3k (k=0..7), 24+2k (k=0..7) and 40+k (k=0..7): 24 spawns total.
REQ-018 phase SHALL become 1, 2 or 3 in the cycle of spawns #1, #9 and #17 respectively, and hold until the next phase change or game end.
REQ-019 At tick_idx 48 the FSM SHALL go to DONE with phase=0 and spawn=0; game_over SHALL assert TICK_CYC*49 cycles after start is sampled.
REQ-020 spawn_cnt SHALL increment in the same cycle as each spawn, saturate at 24, and hold in DONE until the next start.
REQ-021 A 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle out of reset, in every state.
REQ-022 On spawn, mole_idx SHALL load lfsr[2:0]; if that equals the previous mole_idx, it SHALL load lfsr[2:0]+1 mod 8 (no immediate repeat).
REQ-023 Simultaneous start and tick in IDLE/DONE SHALL resolve as start only; no spawn is issued that cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, tick counter=0, tick_idx=0, spawn=0, mole_idx=0, phase=0, spawn_cnt=0, busy=0, game_over=0 and LFSR=LFSR_SEED.
REQ-025 Reset mid-game SHALL abort it with no further spawns; after release the block waits in IDLE for start.

Configuration
REQ-026 Macro MOLE_PAUSE_EN defined: pause=1 in ARM or RUN SHALL freeze the tick counter, tick_idx and state, suppress spawn, and hold all outputs; the LFSR keeps running; timing resumes exactly where it stopped.
REQ-027 MOLE_PAUSE_EN undefined: the pause port and its logic SHALL be absent; timing per REQ-015..019 is unconditional.

Verification
REQ-028 TICK_CYC=4, reset then start pulse at cycle 0 -> spawn at cycles 4,16,28,...,88 (phase 1), 100,108,...,156 (phase 2), 164..192 step 4 (phase 3); game_over high from cycle 196.
REQ-029 Full game -> exactly 24 spawn pulses, spawn_cnt=24, no two consecutive mole_idx values equal, every mole_idx in 0..7.
REQ-030 rst_n low at cycle 50 for 3 cycles -> all outputs 0 asynchronously, no spawn until a new start; next spawn is 4 cycles after that start.
REQ-031 start held high through RUN -> schedule unchanged; start in DONE -> game_over drops next cycle, spawn_cnt=0, new spawn #1 4 cycles later.
REQ-032 With MOLE_PAUSE_EN: pause high for 10 cycles after spawn #2 -> spawn #3 delayed by exactly 10 cycles, phase and spawn_cnt held throughout the pause.
